// File: rtl/pixel_fifo_if.sv
// Pixel stream interface: upstream valid/ready push channel, downstream
// valid/ready pop channel, and the occupancy count reported by the FIFO.
interface pixel_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   level;

    // FIFO side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/pixel_fifo.sv
// Pixel FIFO: dual-port array with a registered read, followed by a two-word
// prefetch stage (head + skid) that hides the read latency. The level counter
// covers everything held: array, in-flight read and prefetch words, so total
// capacity is exactly DEPTH.
module pixel_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    pixel_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   arr_cnt;   // words still in the array, not yet read
    logic                  rd_pend;   // rd_data holds a word read last cycle
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  head_v;
    logic                  skid_v;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  head_v_n;
    logic                  skid_v_n;
    logic [DATA_WIDTH-1:0] head_d_n;
    logic [DATA_WIDTH-1:0] skid_d_n;
    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            pf_total;

    assign bus.in_ready  = !rst && (level_q < DEPTH_L);
    assign bus.out_valid = head_v;
    assign bus.out_data  = head_d;
    assign bus.level     = level_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = head_v && bus.out_ready;

    // Words already committed to the prefetch stage, including the in-flight read.
    assign pf_total = {2'b00, head_v} + {2'b00, skid_v} + {2'b00, rd_pend};

    // Read only entries already written, and only when the prefetch stage will
    // have room for the result after this cycle's pop.
    assign rd_en = (arr_cnt != '0) && (pf_total < 3'd2 + {2'b00, pop});

    // Array write port; the read-while-write case cannot alias because a read
    // needs arr_cnt > 0, which keeps rptr away from wptr whenever a push lands.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= bus.in_data;
    end

    // Registered array read port.
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rptr];
    end

    // Prefetch stage next state: shift on pop, then place the arriving read word
    // into the first free slot.
    always_comb begin
        head_v_n = head_v;
        skid_v_n = skid_v;
        head_d_n = head_d;
        skid_d_n = skid_d;
        if (pop) begin
            head_v_n = skid_v;
            head_d_n = skid_d;
            skid_v_n = 1'b0;
        end
        if (rd_pend) begin
            if (!head_v_n) begin
                head_v_n = 1'b1;
                head_d_n = rd_data;
            end else begin
                skid_v_n = 1'b1;
                skid_d_n = rd_data;
            end
        end
    end

    // Control state: pointers, counters and valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            arr_cnt <= '0;
            level_q <= '0;
            rd_pend <= 1'b0;
            head_v  <= 1'b0;
            skid_v  <= 1'b0;
        end else begin
            wptr    <= wptr + ADDR_WIDTH'(push);
            rptr    <= rptr + ADDR_WIDTH'(rd_en);
            arr_cnt <= arr_cnt + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(rd_en);
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            rd_pend <= rd_en;
            head_v  <= head_v_n;
            skid_v  <= skid_v_n;
        end
    end

    // Prefetch data registers; contents are qualified by the valid flags.
    always_ff @(posedge clk) begin
        head_d <= head_d_n;
        skid_d <= skid_d_n;
    end
endmodule

// File: tb/tb_pixel_fifo.sv
// Bench for pixel_fifo: a queue model of the accepted-but-unconsumed words,
// checked every cycle, plus directed sequences with literal expectations.
module tb_pixel_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    pixel_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model_q[$];
    logic [7:0] popped[$];
    int push_count = 0;
    int pop_count = 0;
    bit started = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && bus.level != 0; i++) step();
        check("drain_done", bus.level, 0);
    endtask

    // Model update on each clock edge: what was accepted and what was consumed.
    always @(posedge clk) begin
        if (rst) begin
            model_q.delete();
            started = 1;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (model_q.size() == 0) check("pop_on_empty", 1, 0);
                else begin
                    check("pop_data", bus.out_data, model_q[0]);
                    void'(model_q.pop_front());
                end
                popped.push_back(bus.out_data);
                pop_count++;
            end
            if (bus.in_valid && bus.in_ready) begin
                model_q.push_back(bus.in_data);
                push_count++;
            end
        end
    end

    // Per-cycle output checks against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("level", bus.level, model_q.size());
            check("in_ready", bus.in_ready, (!rst && model_q.size() < 16));
            if (model_q.size() == 0) check("out_valid_empty", bus.out_valid, 0);
            else if (bus.out_valid) check("out_data_head", bus.out_data, model_q[0]);
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready && !rst;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_level", bus.level, 0);
        check("rst_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        // First-word latency
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11;
        step();
        bus.in_valid = 1'b0;
        check("lat_k_valid", bus.out_valid, 0);
        step();
        check("lat_k1_valid", bus.out_valid, 0);
        step();
        check("lat_k2_valid", bus.out_valid, 1);
        check("lat_k2_data", bus.out_data, 8'h11);
        check("lat_k2_level", bus.level, 1);
        step();
        check("lat_pop_level", bus.level, 0);

        // Fill to capacity with the consumer stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        check("full_level", bus.level, 16);
        check("full_in_ready", bus.in_ready, 0);
        pc = push_count;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hEE;
        step();
        check("full_17th_level", bus.level, 16);
        check("full_17th_rejected", push_count - pc, 0);

        // Pop with in_valid at full: no push this cycle, push next cycle
        popped.delete();
        bus.out_ready = 1'b1;
        bus.in_data = 8'h77;
        step();
        check("fullpop_level", bus.level, 15);
        check("fullpop_in_ready", bus.in_ready, 1);
        check("fullpop_count", popped.size(), 1);
        check("fullpop_first", popped[0], 8'h00);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("fullpop_refill_level", bus.level, 16);
        popped.delete();
        drain();
        check("full_drain_count", popped.size(), 16);
        for (int i = 0; i < 16; i++)
            check("full_drain_order", popped[i], (i < 15) ? (i + 1) : 8'h77);

        // Streaming at one word per cycle
        popped.delete();
        pc = 0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.in_data = 8'(i);
            step();
            if (i == 10) check("stream_level", bus.level, 3);
            if (i == 99) pc = pop_count;
            if (i == 999) check("stream_rate", pop_count - pc, 900);
        end
        bus.in_valid = 1'b0;
        drain();
        check("stream_count", popped.size(), 1000);
        for (int j = 0; j < 1000; j++)
            check("stream_order", popped[j], j & 255);

        // Random handshakes, several pointer wraps
        pc = push_count;
        for (int c = 0; c < 40000 && push_count - pc < 5000; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid = 1'b0;
        check("random_pushes", (push_count - pc) >= 5000, 1);
        drain();

        // Reset mid-operation
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(8'h30 + i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        check("pre_rst_level", bus.level, 7);
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_valid", bus.out_valid, 0);
        check("post_rst_level", bus.level, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        popped.delete();
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        step();
        bus.in_valid = 1'b0;
        drain();
        check("post_rst_count", popped.size(), 1);
        check("post_rst_first", popped[0], 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel/word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, storage address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream word present on in_data.
REQ-006 in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 in_data  input  DATA_WIDTH  upstream word.
REQ-008 out_valid  output  1  out_data holds the oldest stored word.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 out_data  output  DATA_WIDTH  oldest stored word.
REQ-011 level  output  ADDR_WIDTH+1  words held (accepted, not yet consumed), 0..DEPTH.

Function
REQ-012 Push: in_valid && in_ready at a rising edge; exactly that word is stored.
REQ-013 Pop: out_valid && out_ready at a rising edge; the word on out_data is removed.
REQ-014 Storage is a simple dual-port array with a registered read of 1-cycle latency, separate write and read addresses.
REQ-015 A prefetch/skid stage of up to 2 words sits after the array and hides the read latency.
REQ-016 Total capacity is exactly DEPTH words, counting the array, the in-flight read and the prefetch stage.
REQ-017 in_ready = (level < DEPTH); it depends only on registered state and never combinationally on in_valid or out_ready.
REQ-018 out_valid is driven from a register only; it never depends combinationally on in_valid.
REQ-019 Order: words leave in the exact order accepted; no loss or duplication.
REQ-020 First-word latency: a push at edge k into an empty FIFO gives out_valid=1 in the cycle after edge k+2; there is no input-to-output bypass.
REQ-021 Throughput: with in_valid=1 and out_ready=1 held, one push and one pop occur every cycle once the first word has emerged.
REQ-022 Stall: while out_valid=1 and out_ready=0, out_data and out_valid hold stable until a pop occurs.
REQ-023 out_valid=0 when level=0; out_data is don't-care in that case.
REQ-024 level update: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 Write and read pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 with no gap.
REQ-026 Full: level=DEPTH gives in_ready=0, and in_valid is ignored; a pop in the same cycle lets in_ready go 1 the next cycle.
REQ-027 Empty: a pop is never performed and level never underflows.
REQ-028 Simultaneous push/pop at level=1 leaves level=1, and the new word becomes visible without an out_valid gap where read latency allows.
REQ-029 The array write and the prefetch read of the same address in one cycle never return stale data; the read is issued only for entries already written.

Reset
REQ-030 rst=1 at a rising edge sets:
  - level to 0
  - out_valid to 0
  - the internal read/write pointers and prefetch stage to empty.
REQ-031 in_ready=0 during any cycle with rst=1 and becomes 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-operation discards all stored and in-flight words; none may appear on out_data after reset.
REQ-033 Array contents are not cleared by reset.

Verification
REQ-034 Reset, then push 0x11 at edge k with out_ready=1 -> out_valid=1 and out_data=0x11 after edge k+2; level returns to 0 after the pop.
REQ-035 out_ready=0, push 16 words 0x00..0x0F (defaults) -> level=16 and in_ready=0; a 17th in_valid is not accepted; drain gives 0x00..0x0F in order.
REQ-036 Streaming 1000 sequential words with in_valid=1 and out_ready=1 -> 1 word/cycle after latency, output sequence identical, level constant at steady state.
REQ-037 Random in_valid/out_ready (50%) over 5000 words with pointer wrap several times -> scoreboard match, no out_data change during stall, level never above 16 or below 0.
REQ-038 Full FIFO with a pop and in_valid=1 in the same cycle -> no push that cycle, push accepted next cycle, level back to 16.
REQ-039 Assert rst for 1 cycle with level=7 and out_valid=1 -> next cycle out_valid=0 and level=0; next push 0xA5 is the first word out.
